// File: rtl/md_hazard_ctrl_pkg.sv
// Shared pipeline definitions: opcode/ALU-op constants, register
// constants and the multdiv sequencer state encoding.
package pipe_defs;

   typedef logic [31:0] instr_t;
   typedef logic [4:0]  reg_idx_t;

   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_LW    = 5'b01000;
   localparam logic [4:0] OP_SW    = 5'b00111;
   localparam logic [4:0] OP_BNE   = 5'b00010;
   localparam logic [4:0] OP_BLT   = 5'b00110;
   localparam logic [4:0] OP_SETX  = 5'b10101;
   localparam logic [4:0] OP_BEX   = 5'b10110;

   localparam logic [4:0] ALU_MUL  = 5'b00110;
   localparam logic [4:0] ALU_DIV  = 5'b00111;

   localparam reg_idx_t   REG_R0   = 5'd0;
   localparam reg_idx_t   REG_R30  = 5'd30;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } md_state_e;

endpackage

// File: rtl/md_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the execute-stage hazard
// controller. The datapath is the master; the controller is the slave.
interface md_hazard_ctrl_if;
   import pipe_defs::*;

   instr_t      dx_out_ir;
   instr_t      fd_out_ir;
   logic        md_data_ready;
   logic [31:0] md_result;
   logic        md_exception;
   logic        md_ctrl_mult;
   logic        md_ctrl_div;
   logic        stall_front;
   logic        xm_bubble;
   logic        dx_bubble;
   logic        md_result_valid;
   logic [31:0] md_result_out;
   logic        md_over_out;

   modport master (
      output dx_out_ir, fd_out_ir, md_data_ready, md_result, md_exception,
      input  md_ctrl_mult, md_ctrl_div, stall_front, xm_bubble, dx_bubble,
             md_result_valid, md_result_out, md_over_out
   );

   modport slave (
      input  dx_out_ir, fd_out_ir, md_data_ready, md_result, md_exception,
      output md_ctrl_mult, md_ctrl_div, stall_front, xm_bubble, dx_bubble,
             md_result_valid, md_result_out, md_over_out
   );
endinterface

// File: rtl/md_hazard_ctrl_reg_field_decode.sv
// Pulls register indices and class flags out of one instruction word.
// Also reused by the forwarding unit, so it stays purely combinational.
module reg_field_decode
   import pipe_defs::*;
(
   input  instr_t   ir,
   output reg_idx_t rs1,
   output reg_idx_t rs2,
   output reg_idx_t rd,
   output logic     is_r,
   output logic     is_lw,
   output logic     is_sw,
   output logic     is_md,
   output logic     md_is_div
);

   logic [4:0] opcode;
   logic [4:0] alu_op;
   logic       unused_ir_bits;

   assign opcode    = ir[31:27];
   assign alu_op    = ir[6:2];

   assign is_r      = (opcode == OP_RTYPE);
   assign is_lw     = (opcode == OP_LW);
   assign is_sw     = (opcode == OP_SW);
   assign is_md     = is_r && ((alu_op == ALU_MUL) || (alu_op == ALU_DIV));
   assign md_is_div = is_r && (alu_op == ALU_DIV);

   // bex implicitly reads r30; every non-R format reuses [26:22] as its second source
   assign rs1 = ir[21:17];
   assign rd  = ir[26:22];
   assign rs2 = is_r                ? ir[16:12] :
                (opcode == OP_BEX)  ? REG_R30   :
                                      ir[26:22];

   assign unused_ir_bits = &{1'b0, ir[11:7], ir[1:0]};

endmodule

// File: rtl/md_hazard_ctrl.sv
// Execute-stage hazard controller: sequences the multi-cycle multdiv unit
// (freezing the front end and bubbling X/M while it runs) and inserts a
// single D/X bubble on load-use hazards.
module md_hazard_ctrl
   import pipe_defs::*;
#(
   parameter int MD_MAX_CYCLES = 40
) (
   input  logic             clock,
   input  logic             reset,
   md_hazard_ctrl_if.slave  bus
);

   localparam int CNT_W = $clog2(MD_MAX_CYCLES) + 1;

   md_state_e   state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0] result_q, result_d;
   logic        over_q, over_d;

   logic        md_ctrl_mult_c, md_ctrl_div_c, stall_front_c;
   logic        xm_bubble_c, dx_bubble_c, md_result_valid_c;

   reg_idx_t    dx_rs1, dx_rs2, dx_rd, fd_rs1, fd_rs2, fd_rd;
   logic        dx_is_r, dx_is_lw, dx_is_sw, dx_is_md, dx_md_is_div;
   logic        fd_is_r, fd_is_lw, fd_is_sw, fd_is_md, fd_md_is_div;
   logic        load_use;
   logic        unused_decode;

   reg_field_decode u_dx_decode (
      .ir(bus.dx_out_ir), .rs1(dx_rs1), .rs2(dx_rs2), .rd(dx_rd),
      .is_r(dx_is_r), .is_lw(dx_is_lw), .is_sw(dx_is_sw),
      .is_md(dx_is_md), .md_is_div(dx_md_is_div)
   );

   reg_field_decode u_fd_decode (
      .ir(bus.fd_out_ir), .rs1(fd_rs1), .rs2(fd_rs2), .rd(fd_rd),
      .is_r(fd_is_r), .is_lw(fd_is_lw), .is_sw(fd_is_sw),
      .is_md(fd_is_md), .md_is_div(fd_md_is_div)
   );

   assign unused_decode = &{1'b0, dx_rs1, dx_rs2, dx_is_r, dx_is_sw, fd_rd,
                            fd_is_r, fd_is_lw, fd_is_md, fd_md_is_div};

   // Load-use: a store's data register is served by the W->M bypass, so only its base counts
   always_comb begin
      load_use = 1'b0;
      if (dx_is_lw && (dx_rd != REG_R0)) begin
         load_use = (dx_rd == fd_rs1) || ((dx_rd == fd_rs2) && !fd_is_sw);
      end
   end

   // Next-state, counter, result capture and the combinational stall/strobe outputs
   always_comb begin
      state_d           = state_q;
      cnt_d             = cnt_q;
      result_d          = result_q;
      over_d            = over_q;
      md_ctrl_mult_c    = 1'b0;
      md_ctrl_div_c     = 1'b0;
      stall_front_c     = 1'b0;
      xm_bubble_c       = 1'b0;
      dx_bubble_c       = 1'b0;
      md_result_valid_c = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (dx_is_md) begin
               md_ctrl_mult_c = !dx_md_is_div;
               md_ctrl_div_c  = dx_md_is_div;
               stall_front_c  = 1'b1;
               xm_bubble_c    = 1'b1;
               cnt_d          = '0;
               state_d        = ST_BUSY;
            end else if (load_use) begin
               stall_front_c  = 1'b1;
               dx_bubble_c    = 1'b1;
            end
         end
         ST_BUSY: begin
            stall_front_c = 1'b1;
            xm_bubble_c   = 1'b1;
            cnt_d         = cnt_q + CNT_W'(1);
            if (bus.md_data_ready) begin
               result_d = bus.md_result;
               over_d   = bus.md_exception;
               state_d  = ST_DONE;
            end else if (cnt_q == CNT_W'(MD_MAX_CYCLES - 1)) begin
               result_d = 32'h0;
               over_d   = 1'b1;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            md_result_valid_c = 1'b1;
            state_d           = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (reset) begin
         md_ctrl_mult_c    = 1'b0;
         md_ctrl_div_c     = 1'b0;
         stall_front_c     = 1'b0;
         xm_bubble_c       = 1'b0;
         dx_bubble_c       = 1'b0;
         md_result_valid_c = 1'b0;
      end
   end

   // State, watchdog counter and the registered result/overflow
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         result_q <= 32'h0;
         over_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         over_q   <= over_d;
      end
   end

   assign bus.md_ctrl_mult    = md_ctrl_mult_c;
   assign bus.md_ctrl_div     = md_ctrl_div_c;
   assign bus.stall_front     = stall_front_c;
   assign bus.xm_bubble       = xm_bubble_c;
   assign bus.dx_bubble       = dx_bubble_c;
   assign bus.md_result_valid = md_result_valid_c;
   assign bus.md_result_out   = result_q;
   assign bus.md_over_out     = over_q;

endmodule

// File: tb/tb_md_hazard_ctrl.sv
// Bench for md_hazard_ctrl: directed scenarios plus randomized traffic
// checked against a timeline model of the multdiv and load-use rules.
module tb_md_hazard_ctrl;

   localparam int MAX = 40;

   logic clock = 1'b0;
   logic reset;

   md_hazard_ctrl_if bus();

   md_hazard_ctrl #(.MD_MAX_CYCLES(MAX)) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   // Free-running pipeline clock
   always #5 clock = ~clock;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_res = 32'h0;
   logic        model_over = 1'b0;
   logic        obs_stall;

   function automatic logic [31:0] enc_r(logic [4:0] alu, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
      return {5'b00000, rd, rs1, rs2, 5'b00000, alu, 2'b00};
   endfunction

   function automatic logic [31:0] enc_i(logic [4:0] op, logic [4:0] rd, logic [4:0] rs, logic [16:0] imm);
      return {op, rd, rs, imm};
   endfunction

   function automatic logic [4:0] rand_reg();
      if ($urandom_range(0, 5) == 0) return 5'd30;
      return 5'($urandom_range(0, 3));
   endfunction

   function automatic logic [31:0] rand_fd();
      case ($urandom_range(0, 5))
         0:       return enc_r(5'd0, rand_reg(), rand_reg(), rand_reg());
         1:       return enc_i(5'b00101, rand_reg(), rand_reg(), 17'($urandom));
         2:       return enc_i(5'b00111, rand_reg(), rand_reg(), 17'($urandom));
         3:       return enc_i(5'b01000, rand_reg(), rand_reg(), 17'($urandom));
         4:       return {5'b10110, 27'($urandom)};
         default: return enc_i(5'b00010, rand_reg(), rand_reg(), 17'($urandom));
      endcase
   endfunction

   function automatic logic [31:0] rand_dx_idle();
      case ($urandom_range(0, 3))
         0, 1:    return enc_i(5'b01000, rand_reg(), rand_reg(), 17'($urandom));
         2:       return enc_r(5'd0, rand_reg(), rand_reg(), rand_reg());
         default: return enc_i(5'b00101, rand_reg(), rand_reg(), 17'($urandom));
      endcase
   endfunction

   // Expected load-use stall from the instruction pair, straight from the ISA source rules
   function automatic bit expect_load_use(logic [31:0] dx, logic [31:0] fd);
      logic [4:0] dst, src_a, src_b, fop;
      fop = fd[31:27];
      dst = dx[26:22];
      if (dx[31:27] != 5'b01000 || dst == 5'd0) return 1'b0;
      src_a = fd[21:17];
      if (fop == 5'b00000)      src_b = fd[16:12];
      else if (fop == 5'b10110) src_b = 5'd30;
      else                      src_b = fd[26:22];
      if (fop == 5'b00111) return dst == src_a;
      return (dst == src_a) || (dst == src_b);
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(logic [31:0] dx, logic [31:0] fd, logic rdy, logic [31:0] res, logic exc);
      bus.dx_out_ir     = dx;
      bus.fd_out_ir     = fd;
      bus.md_data_ready = rdy;
      bus.md_result     = res;
      bus.md_exception  = exc;
   endtask

   task automatic check_output(string tag, bit e_mult, bit e_div, bit e_stall, bit e_xm,
                               bit e_dx, bit e_valid, logic [31:0] e_res, bit e_over);
      @(negedge clock);
      obs_stall = bus.stall_front;
      check({tag, ".mult"},  32'(bus.md_ctrl_mult),    32'(e_mult));
      check({tag, ".div"},   32'(bus.md_ctrl_div),     32'(e_div));
      check({tag, ".stall"}, 32'(bus.stall_front),     32'(e_stall));
      check({tag, ".xmb"},   32'(bus.xm_bubble),       32'(e_xm));
      check({tag, ".dxb"},   32'(bus.dx_bubble),       32'(e_dx));
      check({tag, ".valid"}, 32'(bus.md_result_valid), 32'(e_valid));
      check({tag, ".res"},   bus.md_result_out,        e_res);
      check({tag, ".over"},  32'(bus.md_over_out),     32'(e_over));
      @(posedge clock);
      #1;
   endtask

   task automatic idle_cycle(string tag, logic [31:0] dx, logic [31:0] fd);
      bit hz;
      hz = expect_load_use(dx, fd);
      apply_stimulus(dx, fd, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      check_output(tag, 1'b0, 1'b0, hz, 1'b0, hz, 1'b0, model_res, model_over);
   endtask

   // One multdiv op: start at j=0, ready at j=k (k outside 1..MAX means never), DONE at j=kend+1
   task automatic run_md(string tag, logic [31:0] ir, int k, logic [31:0] res, bit exc);
      bit used, is_div;
      int kend, stall_seen;
      used   = (k >= 1) && (k <= MAX);
      kend   = used ? k : MAX;
      is_div = (ir[6:2] == 5'b00111);
      stall_seen = 0;

      apply_stimulus(ir, rand_fd(), 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      check_output({tag, ".start"}, !is_div, is_div, 1'b1, 1'b1, 1'b0, 1'b0, model_res, model_over);
      stall_seen += int'(obs_stall);

      for (int j = 1; j <= kend; j++) begin
         if (j == k) apply_stimulus(ir, rand_fd(), 1'b1, res, exc);
         else        apply_stimulus(ir, rand_fd(), 1'b0, $urandom, 1'($urandom_range(0, 1)));
         check_output({tag, ".busy"}, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, model_res, model_over);
         stall_seen += int'(obs_stall);
      end

      model_res  = used ? res : 32'h0;
      model_over = used ? exc : 1'b1;

      apply_stimulus(ir, rand_fd(), 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      check_output({tag, ".done"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, model_res, model_over);
      stall_seen += int'(obs_stall);

      check({tag, ".stall_len"}, 32'(stall_seen), 32'(kend + 1));
   endtask

   // Directed scenarios followed by randomized mixed traffic
   initial begin
      logic [31:0] mul_ir;
      reset = 1'b1;
      apply_stimulus(32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
      @(posedge clock);
      #1;
      check_output("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      reset = 1'b0;
      idle_cycle("idle0", 32'h0, 32'h0);

      run_md("mul16", enc_r(5'b00110, 5'd3, 5'd1, 5'd2), 16, 32'h0000_0C00, 1'b0);
      run_md("divz", enc_r(5'b00111, 5'd4, 5'd1, 5'd0), 5, 32'h0, 1'b1);
      run_md("wdog", enc_r(5'b00110, 5'd5, 5'd6, 5'd7), -1, 32'hDEAD_BEEF, 1'b0);

      idle_cycle("lu_add", enc_i(5'b01000, 5'd5, 5'd1, 17'd0), enc_r(5'd0, 5'd6, 5'd5, 5'd2));
      idle_cycle("lu_after", 32'h0, enc_r(5'd0, 5'd6, 5'd5, 5'd2));
      idle_cycle("lu_swdata", enc_i(5'b01000, 5'd5, 5'd1, 17'd0), enc_i(5'b00111, 5'd5, 5'd7, 17'd0));
      idle_cycle("lu_swbase", enc_i(5'b01000, 5'd5, 5'd1, 17'd0), enc_i(5'b00111, 5'd2, 5'd5, 17'd0));
      idle_cycle("lu_r0", enc_i(5'b01000, 5'd0, 5'd1, 17'd0), enc_r(5'd0, 5'd6, 5'd0, 5'd0));
      idle_cycle("lu_bex", enc_i(5'b01000, 5'd30, 5'd1, 17'd0), {5'b10110, 27'd0});

      run_md("b2b_mul", enc_r(5'b00110, 5'd8, 5'd1, 5'd2), 3, 32'h1234_5678, 1'b0);
      run_md("b2b_div", enc_r(5'b00111, 5'd9, 5'd1, 5'd2), 2, 32'h0000_0042, 1'b0);

      mul_ir = enc_r(5'b00110, 5'd10, 5'd1, 5'd2);
      apply_stimulus(mul_ir, 32'h0, 1'b0, 32'h0, 1'b0);
      check_output("rst_busy.start", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, model_res, model_over);
      for (int j = 1; j <= 3; j++) begin
         apply_stimulus(mul_ir, 32'h0, 1'b0, 32'h0, 1'b0);
         check_output("rst_busy.busy", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, model_res, model_over);
      end
      reset = 1'b1;
      apply_stimulus(mul_ir, 32'h0, 1'b0, 32'h0, 1'b0);
      check_output("rst_busy.rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, model_res, model_over);
      reset = 1'b0;
      model_res  = 32'h0;
      model_over = 1'b0;
      for (int j = 0; j < 3; j++) begin
         apply_stimulus(32'h0, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b1);
         check_output("rst_busy.late", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, model_res, model_over);
      end

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            run_md("rnd_md",
                   enc_r(($urandom_range(0, 1) == 0) ? 5'b00110 : 5'b00111, rand_reg(), rand_reg(), rand_reg()),
                   int'($urandom_range(1, 12)), $urandom, 1'($urandom_range(0, 1)));
         end else begin
            idle_cycle("rnd_idle", rand_dx_idle(), rand_fd());
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/md_hazard_ctrl.md
# md_hazard_ctrl

Execute-stage hazard controller for the 5-stage pipeline. Starts the multi-cycle multiply/divide unit when a `mul`/`div` reaches D/X and freezes PC, F/D and D/X while it runs. Injects bubbles into X/M while frozen and hands the finished result and overflow flag to the X/M latch. Also detects load-use hazards between D/X and F/D and inserts a one-cycle D/X bubble. Its `md_over_out` feeds `xm_out_over`, which the forwarding unit uses for the r30 redirect.

## Interface
Parameters:
- `MD_MAX_CYCLES`, default 40: watchdog limit on BUSY cycles before a forced exception.

Ports:
- `clock`  in  1  pipeline clock, rising edge
- `reset`  in  1  synchronous, active-high; all state cleared on the edge where it is high
- `dx_out_ir`  in  32  instruction in D/X
- `fd_out_ir`  in  32  instruction in F/D
- `md_data_ready`  in  1  multdiv completion strobe
- `md_result`  in  32  multdiv result, valid with `md_data_ready`
- `md_exception`  in  1  multdiv overflow/div-by-zero, valid with `md_data_ready`
- `md_ctrl_mult`  out  1  one-cycle start pulse, multiply
- `md_ctrl_div`  out  1  one-cycle start pulse, divide
- `stall_front`  out  1  hold PC, F/D, D/X
- `xm_bubble`  out  1  load nop into X/M
- `dx_bubble`  out  1  load nop into D/X (load-use)
- `md_result_valid`  out  1  X/M must take `md_result_out` instead of the ALU output
- `md_result_out`  out  32  registered multdiv result
- `md_over_out`  out  1  registered exception, routed as X/M overflow

## Operation
- Decode: R-type is opcode `00000`. ALU op `[6:2]` `00110` is mul and `00111` is div. lw is `01000`, sw is `00111`, bne is `00010`, blt is `00110`, bex is `10110`.
- Sources:
  - rs1 = `[21:17]`.
  - rs2 = `[16:12]` for R-type, r30 for bex, otherwise `[26:22]`.
  - rd = `[26:22]`.
- FSM states: IDLE, BUSY, DONE. All three are registered.
- IDLE:
  - If D/X holds mul/div, assert the matching `md_ctrl_*`, `stall_front` and `xm_bubble` combinationally, then go to BUSY.
  - Otherwise evaluate load-use.
  - `md_data_ready` is ignored in IDLE.
- BUSY:
  - `stall_front=1`, `xm_bubble=1`. The cycle counter increments.
  - On `md_data_ready`, capture `md_result`/`md_exception` into the output registers and go to DONE.
  - When the counter reaches `MD_MAX_CYCLES-1` without ready, capture result 0 with exception 1 and go to DONE.
- DONE:
  - `stall_front=0`, `xm_bubble=0`, `md_result_valid=1`. The instruction advances into X/M this cycle.
  - Never restarts. Next state is always IDLE, so a back-to-back mul in the new D/X starts on the following cycle.
- Load-use (IDLE only, no md start):
  - Triggers when D/X is lw with rd≠0 and rd equals the F/D rs1 or rs2.
  - Then `stall_front=1` and `dx_bubble=1` for exactly one cycle.
  - Exception: if F/D is sw and the only match is on its data register (`[26:22]`), do not stall; the W→M data bypass covers it.
- Only one of `xm_bubble` and `dx_bubble` is ever asserted at a time.

## Timing
- Reset values:
  - state IDLE, counter 0.
  - `md_result_out=0`, `md_over_out=0`.
  - All strobes and stall signals 0.
- Reset mid-BUSY returns to IDLE with no start pulse. A late `md_data_ready` is then ignored.
- Start pulse at cycle T; BUSY from T+1. If ready arrives at T+k (k≥1), DONE is at T+k+1.
- Total front stall = k+1 cycles. Result latency from ready = 1 cycle.
- `md_ctrl_*` is high for exactly one cycle per instruction.
- Counter is `$clog2(MD_MAX_CYCLES)+1` bits wide and is cleared on entry to BUSY.
- Load-use stall is combinational in the hazard cycle. Since the stall holds F/D and D/X there, the lw moves on and the condition does not re-fire.

## Structure
- Shared package `pipe_defs`:
  - opcode and ALU-op constants (R-type, lw, sw, bne, blt, setx, bex, mul, div).
  - r30 constant.
  - FSM state encoding.
- One sub-module, `reg_field_decode`: IR → rs1, rs2, rd, plus `is_r`, `is_lw`, `is_sw`, `is_md`, `md_is_div`. Instantiated twice, for D/X and F/D, and reusable by the forwarding unit.

## Test plan
- mul r3,r1,r2 in D/X, ready at T+16, result 0x0000_0C00 → `md_ctrl_mult` only at T; stall T..T+16; DONE at T+17 with valid=1, out=0x0C00, over=0.
- div by zero, ready at T+5 with exception → DONE at T+6, `md_over_out=1`, nop in X/M for T..T+5.
- Ready never arrives, `MD_MAX_CYCLES=40` → forced DONE with out=0, over=1; exactly 41 stall cycles.
- lw r5,0(r1) in D/X, add r6,r5,r2 in F/D → one cycle of `stall_front`=`dx_bubble`=1. Same case with sw r5,0(r7) in F/D → no stall. lw r0 → no stall.
- Back-to-back mul,div → second start pulse is issued the cycle after DONE, never during DONE.
- Reset asserted at BUSY cycle 3, then ready pulses → IDLE, all outputs 0, no valid.
